// File: rtl/snake_pkg.sv
// Shared types and geometry constants for the snake segment sequencer.
// A segment word is {x, y} so that it maps directly onto one register-file entry.
package snake_pkg;

   localparam int DEPTH    = 15;
   localparam int IDX_W    = 4;
   localparam int COORD_W  = 10;
   localparam int STEP     = 8;
   localparam int X_MAX    = 640;
   localparam int Y_MAX    = 480;
   localparam int INIT_LEN = 3;
   localparam int INIT_X   = 320;
   localparam int INIT_Y   = 240;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } seg_t;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_SHIFT,
      ST_HEAD
   } state_t;

   // Opposite directions share the axis bit and differ in the sense bit.
   function automatic logic is_reverse(input dir_t a, input dir_t b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction

endpackage

// File: rtl/snake_head_next.sv
// Next head position: one STEP in the given direction, wrapping at the playfield edges.
// Arithmetic is one bit wider than a coordinate so the bound test sees the carry.
module snake_head_next
   import snake_pkg::*;
(
   input  seg_t i_head,
   input  dir_t i_dir,
   output seg_t o_new_head
);

   localparam logic [COORD_W:0] C_STEP   = (COORD_W+1)'(STEP);
   localparam logic [COORD_W:0] C_X_MAX  = (COORD_W+1)'(X_MAX);
   localparam logic [COORD_W:0] C_Y_MAX  = (COORD_W+1)'(Y_MAX);
   localparam logic [COORD_W:0] C_X_WRAP = (COORD_W+1)'(X_MAX - STEP);
   localparam logic [COORD_W:0] C_Y_WRAP = (COORD_W+1)'(Y_MAX - STEP);

   logic [COORD_W:0] w_x, w_y, w_x_inc, w_y_inc, w_x_dec, w_y_dec;

   assign w_x     = {1'b0, i_head.x};
   assign w_y     = {1'b0, i_head.y};
   assign w_x_inc = w_x + C_STEP;
   assign w_y_inc = w_y + C_STEP;
   assign w_x_dec = (w_x < C_STEP) ? C_X_WRAP : w_x - C_STEP;
   assign w_y_dec = (w_y < C_STEP) ? C_Y_WRAP : w_y - C_STEP;

   // NOTE: every output is given a default before the case so no path can infer a latch.
   always_comb begin
      o_new_head = i_head;
      unique case (i_dir)
         UP:    o_new_head.y = w_y_dec[COORD_W-1:0];
         DOWN:  o_new_head.y = (w_y_inc >= C_Y_MAX) ? '0 : w_y_inc[COORD_W-1:0];
         LEFT:  o_new_head.x = w_x_dec[COORD_W-1:0];
         RIGHT: o_new_head.x = (w_x_inc >= C_X_MAX) ? '0 : w_x_inc[COORD_W-1:0];
      endcase
   end

endmodule

// File: rtl/snake_body_shifter.sv
// Per-tick sequencer for the segment register file: copies segments tail-first,
// writes the new head at slot 0, handles growth and latches self-collision.
module snake_body_shifter
   import snake_pkg::*;
(
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   tick,
   input  logic [1:0]             dir_in,
   input  logic                   grow,
   input  logic [2*COORD_W-1:0]   rf_rdata,
   output logic                   rf_ld,
   output logic [IDX_W-1:0]       rf_waddr,
   output logic [IDX_W-1:0]       rf_raddr,
   output logic [2*COORD_W-1:0]   rf_wdata,
   output logic [IDX_W-1:0]       length,
   output logic                   busy,
   output logic                   done,
   output logic                   self_hit,
   output logic                   tick_drop
);

   localparam logic [IDX_W-1:0]   C_DEPTH    = IDX_W'(DEPTH);
   localparam logic [IDX_W-1:0]   C_INIT_LEN = IDX_W'(INIT_LEN);
   localparam logic [IDX_W-1:0]   C_INIT_END = IDX_W'(INIT_LEN - 1);
   localparam logic [COORD_W-1:0] C_INIT_X   = COORD_W'(INIT_X);
   localparam logic [COORD_W-1:0] C_INIT_Y   = COORD_W'(INIT_Y);
   localparam logic [COORD_W-1:0] C_STEP     = COORD_W'(STEP);

   state_t           r_state, w_state_next;
   logic [IDX_W-1:0] r_k, r_i, r_len;
   dir_t             r_dir, w_dir_req, w_dir_eff;
   seg_t             r_head, r_new_head, w_new_head, w_init_seg;
   logic             r_grow_pend, r_self_hit, r_done, r_tick_drop;
   logic             w_ld, w_hit_cmp;

   assign w_dir_req  = dir_t'(dir_in);
   assign w_dir_eff  = is_reverse(w_dir_req, r_dir) ? r_dir : w_dir_req;
   assign w_init_seg = '{x: C_INIT_X - COORD_W'(r_k) * C_STEP, y: C_INIT_Y};

   // Only segments that survive this step (indices 0..length-2) count as a collision.
   assign w_hit_cmp = (({1'b0, r_i} + (IDX_W+1)'(2)) <= {1'b0, r_len}) &&
                      (rf_rdata == r_new_head);

   snake_head_next u_head_next (
      .i_head     (r_head),
      .i_dir      (w_dir_eff),
      .o_new_head (w_new_head)
   );

   always_comb begin
      w_state_next = r_state;
      w_ld         = 1'b0;
      rf_waddr     = '0;
      rf_raddr     = '0;
      rf_wdata     = '0;
      unique case (r_state)
         ST_INIT: begin
            w_ld     = 1'b1;
            rf_waddr = r_k;
            rf_wdata = w_init_seg;
            if (r_k == C_INIT_END) w_state_next = ST_IDLE;
         end
         ST_IDLE: if (tick) w_state_next = ST_SHIFT;
         ST_SHIFT: begin
            w_ld     = 1'b1;
            rf_raddr = r_i;
            rf_waddr = r_i + IDX_W'(1);
            rf_wdata = rf_rdata;
            if (r_i == '0) w_state_next = ST_HEAD;
         end
         ST_HEAD: begin
            w_ld         = 1'b1;
            rf_wdata     = r_new_head;
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= ST_INIT;
         r_k         <= '0;
         r_i         <= '0;
         r_len       <= '0;
         r_dir       <= RIGHT;
         r_head      <= '{x: C_INIT_X, y: C_INIT_Y};
         r_new_head  <= '0;
         r_grow_pend <= 1'b0;
         r_self_hit  <= 1'b0;
         r_done      <= 1'b0;
         r_tick_drop <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_done      <= (r_state == ST_HEAD);
         r_tick_drop <= tick && (r_state != ST_IDLE);
         if (grow && (r_state != ST_INIT)) r_grow_pend <= 1'b1;
         unique case (r_state)
            ST_INIT: begin
               r_k <= r_k + IDX_W'(1);
               if (r_k == C_INIT_END) r_len <= C_INIT_LEN;
            end
            ST_IDLE: if (tick) begin
               r_dir      <= w_dir_eff;
               r_new_head <= w_new_head;
               r_i        <= (r_len == C_DEPTH) ? r_len - IDX_W'(2) : r_len - IDX_W'(1);
            end
            ST_SHIFT: begin
               if (w_hit_cmp) r_self_hit <= 1'b1;
               r_i <= r_i - IDX_W'(1);
            end
            ST_HEAD: begin
               r_head <= r_new_head;
               if (r_grow_pend && (r_len < C_DEPTH)) r_len <= r_len + IDX_W'(1);
               // A grow arriving during the head write belongs to the next step.
               r_grow_pend <= grow;
            end
         endcase
      end
   end

   assign rf_ld     = w_ld & ~Reset;
   assign length    = r_len;
   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;
   assign self_hit  = r_self_hit;
   assign tick_drop = r_tick_drop;

endmodule

// File: tb/tb_snake_body_shifter.sv
// Scoreboard bench: a list-based snake model predicts each step's outcome,
// a monitor compares it against the register-file image whenever done pulses.
module tb_snake_body_shifter;

   localparam int STEP  = 8;
   localparam int X_MAX = 640;
   localparam int Y_MAX = 480;
   localparam int DEPTH = 15;

   logic        Clk = 1'b0, Reset = 1'b1, tick = 1'b0, grow = 1'b0;
   logic [1:0]  dir_in = 2'd0;
   logic [19:0] rf_rdata, rf_wdata;
   logic        rf_ld, busy, done, self_hit, tick_drop;
   logic [3:0]  rf_waddr, rf_raddr, length;

   always #5 Clk = ~Clk;

   snake_body_shifter dut (
      .Clk(Clk), .Reset(Reset), .tick(tick), .dir_in(dir_in), .grow(grow),
      .rf_rdata(rf_rdata), .rf_ld(rf_ld), .rf_waddr(rf_waddr), .rf_raddr(rf_raddr),
      .rf_wdata(rf_wdata), .length(length), .busy(busy), .done(done),
      .self_hit(self_hit), .tick_drop(tick_drop)
   );

   // Register file the sequencer drives: synchronous write, combinational read.
   logic [19:0] rf_mem [16];
   always @(posedge Clk) if (rf_ld) rf_mem[rf_waddr] <= rf_wdata;
   assign rf_rdata = rf_mem[rf_raddr];

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int n_checks = 0, n_fail = 0;

   typedef struct {
      int               cyc;
      int               len;
      bit               hit;
      logic [14:0][19:0] segs;
   } exp_t;

   exp_t exp_q[$];
   int   drop_q[$];

   // Behavioural model: body as coordinate lists, head at index 0.
   int m_x[DEPTH], m_y[DEPTH];
   int m_len, m_dir;
   bit m_hit, m_pend;

   function automatic logic [19:0] seg(input int x, input int y);
      return {x[9:0], y[9:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_len = 3; m_dir = 3; m_hit = 0; m_pend = 0;
      for (int k = 0; k < DEPTH; k++) begin
         m_x[k] = 320 - k * STEP;
         m_y[k] = 240;
      end
   endtask

   task automatic model_step(input int d, input int t, output int n);
      bit   rev, g;
      int   nx, ny, old_len;
      exp_t e;
      rev = (d == 0 && m_dir == 1) || (d == 1 && m_dir == 0) ||
            (d == 2 && m_dir == 3) || (d == 3 && m_dir == 2);
      if (!rev) m_dir = d;
      nx = m_x[0];
      ny = m_y[0];
      case (m_dir)
         0:       ny = (ny < STEP) ? Y_MAX - STEP : ny - STEP;
         1:       ny = (ny + STEP >= Y_MAX) ? 0 : ny + STEP;
         2:       nx = (nx < STEP) ? X_MAX - STEP : nx - STEP;
         default: nx = (nx + STEP >= X_MAX) ? 0 : nx + STEP;
      endcase
      old_len = m_len;
      for (int j = 0; j <= old_len - 2; j++)
         if (m_x[j] == nx && m_y[j] == ny) m_hit = 1;
      g = m_pend && (old_len < DEPTH);
      m_pend = 0;
      if (g) m_len++;
      for (int j = m_len - 1; j >= 1; j--) begin
         m_x[j] = m_x[j-1];
         m_y[j] = m_y[j-1];
      end
      m_x[0] = nx;
      m_y[0] = ny;
      n = (old_len == DEPTH) ? DEPTH - 1 : old_len;
      e.cyc = t + n + 2;
      e.len = m_len;
      e.hit = m_hit;
      for (int j = 0; j < DEPTH; j++) e.segs[j] = seg(m_x[j], m_y[j]);
      exp_q.push_back(e);
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   initial forever begin
      @(negedge Clk);
      if (!Reset) begin
         if (!busy) check("rf_ld_idle", rf_ld, 0);
         if (done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL done_unexpected: done seen at cycle %0d with nothing expected", cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("done_cycle", cyc, e.cyc);
               check("length", length, e.len);
               check("self_hit", self_hit, e.hit);
               for (int j = 0; j < e.len; j++)
                  check($sformatf("slot%0d", j), rf_mem[j], e.segs[j]);
            end
         end
         if (tick_drop) begin
            n_checks++;
            if (drop_q.size() == 0) begin
               n_fail++;
               $display("FAIL drop_unexpected: tick_drop seen at cycle %0d with nothing expected", cyc);
            end else begin
               check("drop_cycle", cyc, drop_q.pop_front());
            end
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic wait_done();
      int b = 0;
      while (!done && b < 40) begin
         wait_cycles(1);
         b++;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got no done within 40 cycles, required done");
      end
   endtask

   task automatic step(input int d, input bit g, input bit drop);
      int n, t;
      tick   = 1'b1;
      dir_in = d[1:0];
      grow   = g;
      t      = cyc;
      if (g) m_pend = 1;
      model_step(d, t, n);
      wait_cycles(1);
      tick   = 1'b0;
      grow   = 1'b0;
      dir_in = 2'($urandom_range(3, 0));
      if (drop) begin
         wait_cycles($urandom_range(n - 1, 0));
         tick   = 1'b1;
         dir_in = 2'($urandom_range(3, 0));
         drop_q.push_back(cyc + 1);
         wait_cycles(1);
         tick = 1'b0;
      end
      wait_done();
   endtask

   task automatic pulse_grow();
      grow   = 1'b1;
      m_pend = 1;
      wait_cycles(1);
      grow = 1'b0;
   endtask

   task automatic init_check();
      int b = 0;
      while (busy && b < 10) begin
         wait_cycles(1);
         b++;
      end
      check("init_busy_drop", busy, 0);
      check("init_length", length, 3);
      check("init_self_hit", self_hit, 0);
      check("init_slot0", rf_mem[0], seg(320, 240));
      check("init_slot1", rf_mem[1], seg(312, 240));
      check("init_slot2", rf_mem[2], seg(304, 240));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      logic [19:0] old13;

      Reset = 1'b1;
      wait_cycles(2);
      check("rst_busy", busy, 1);
      check("rst_length", length, 0);
      check("rst_done", done, 0);
      check("rst_self_hit", self_hit, 0);
      check("rst_tick_drop", tick_drop, 0);
      check("rst_rf_ld", rf_ld, 0);
      model_reset();
      Reset = 1'b0;
      init_check();

      step(3, 0, 0);
      check("t2_head", rf_mem[0], seg(328, 240));
      check("t2_tail", rf_mem[2], seg(312, 240));

      pulse_grow();
      step(3, 0, 0);
      check("t4_length", length, 4);
      check("t4_tail", rf_mem[3], seg(312, 240));

      step(2, 0, 0);
      check("t9_no_reverse", rf_mem[0], seg(344, 240));

      step(3, 0, 1);

      while (m_x[0] != X_MAX - STEP) step(3, 0, $urandom_range(3, 0) == 0);
      step(3, 0, 0);
      check("t3_xwrap", rf_mem[0][19:10], 0);

      while (m_y[0] != 0) step(0, m_len < DEPTH, 0);
      step(0, 0, 0);
      check("t3_ywrap", rf_mem[0][9:0], Y_MAX - STEP);

      check("t5_full", length, DEPTH);
      old13 = seg(m_x[13], m_y[13]);
      step(0, 1, 0);
      check("t5_len_cap", length, DEPTH);
      check("t5_slot14", rf_mem[14], old13);
      check("t6_no_hit_yet", self_hit, 0);

      step(2, 0, 0);
      step(1, 0, 0);
      step(3, 0, 0);
      check("t6_self_hit", self_hit, 1);
      step(3, 0, 0);
      check("t6_sticky", self_hit, 1);

      tick   = 1'b1;
      dir_in = 2'd3;
      wait_cycles(1);
      tick = 1'b0;
      wait_cycles(2);
      Reset = 1'b1;
      wait_cycles(2);
      exp_q.delete();
      drop_q.delete();
      model_reset();
      Reset = 1'b0;
      init_check();

      repeat (80) begin
         if ($urandom_range(3, 0) == 0) pulse_grow();
         if ($urandom_range(2, 0) == 0) wait_cycles($urandom_range(3, 1));
         step($urandom_range(3, 0), $urandom_range(3, 0) == 0, $urandom_range(4, 0) == 0);
      end

      wait_cycles(5);
      check("scoreboard_empty", exp_q.size(), 0);
      check("drop_queue_empty", drop_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
